// File: rtl/instr_fetch_decode_pkg.sv
// Shared opcodes, instruction layout and FSM encoding for the fetch/decode/issue stage.
package instr_fetch_decode_pkg;

    localparam int INSTR_W = 24;

    localparam logic [3:0] OP_ADD      = 4'h0;
    localparam logic [3:0] OP_SUB      = 4'h1;
    localparam logic [3:0] OP_MUL      = 4'h2;
    localparam logic [3:0] OP_DIV      = 4'h3;
    localparam logic [3:0] OP_MOD      = 4'h4;
    localparam logic [3:0] OP_JMP      = 4'hE;
    localparam logic [3:0] OP_NOP_HALT = 4'hF;

    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] addr;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.func = w[FUNC_LSB +: 4];
        d.rd   = w[RD_LSB   +: 4];
        d.rs1  = w[RS1_LSB  +: 4];
        d.rs2  = w[RS2_LSB  +: 4];
        d.addr = w[ADDR_LSB +: 8];
        return d;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] f);
        case (f)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_decode_hazard_scoreboard.sv
// Remembers the destination of the last DEPTH issue slots and flags a read of any of them.
module hazard_scoreboard #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       issue_vld,
    input  logic [3:0] issue_rd,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    output logic       stall
);

    logic [DEPTH-1:0] slot_vld;
    logic [3:0]       slot_rd [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot_vld <= '0;
        end else if (shift_en) begin
            slot_vld[0] <= issue_vld;
            for (int i = 1; i < DEPTH; i++) slot_vld[i] <= slot_vld[i-1];
        end
    end

    // rd of an invalid slot is never consulted, so it needs no reset
    always_ff @(posedge clk) begin
        if (shift_en) begin
            slot_rd[0] <= issue_rd;
            for (int i = 1; i < DEPTH; i++) slot_rd[i] <= slot_rd[i-1];
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (slot_rd[i] == rs1 || slot_rd[i] == rs2)) stall = 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Program store, PC and decode/issue FSM feeding the no-forwarding execute pipeline.
// Issues bubbles while a source register is still in flight.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int  HAZARD_WINDOW = 3,
    parameter int  PROG_DEPTH    = 256,
    localparam int PC_W          = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [3:0]         rd,
    output logic [3:0]         func,
    output logic [7:0]         addr,
    output logic               issue_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];
    instr_t             word;
    instr_t             issue_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic               valid_nxt;
    logic               illegal_nxt;
    logic               stall;
    logic               hist_shift;
    logic               hist_clear;

    assign word = decode(prog_mem[pc]);

    always_ff @(posedge clk) begin
        if (prog_we && state != ST_RUN) prog_mem[prog_addr] <= prog_data;
    end

    hazard_scoreboard #(.DEPTH(HAZARD_WINDOW)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clear    (hist_clear),
        .shift_en (hist_shift),
        .issue_vld(valid_nxt),
        .issue_rd (word.rd),
        .rs1      (word.rs1),
        .rs2      (word.rs2),
        .stall    (stall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        illegal_nxt = illegal;
        valid_nxt   = 1'b0;
        hist_shift  = 1'b0;
        hist_clear  = 1'b0;
        issue_nxt   = '{func: OP_NOP_HALT, rd: rd, rs1: rs1, rs2: rs2, addr: addr};
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt   = ST_RUN;
                    pc_nxt      = '0;
                    illegal_nxt = 1'b0;
                    hist_clear  = 1'b1;
                end
            end
            ST_RUN: begin
                // every RUN cycle occupies one history slot, bubble or not
                hist_shift = 1'b1;
                if (is_alu_op(word.func)) begin
                    if (!stall) begin
                        issue_nxt = word;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc + PC_W'(1);
                    end
                end else if (word.func == OP_JMP) begin
                    pc_nxt = PC_W'(word.addr);
                end else if (word.func == OP_NOP_HALT) begin
                    state_nxt = ST_HALT;
                end else begin
                    illegal_nxt = 1'b1;
                    pc_nxt      = pc + PC_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            func        <= OP_NOP_HALT;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            addr        <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            pc                         <= pc_nxt;
            {func, rd, rs1, rs2, addr} <= issue_nxt;
            issue_valid                <= valid_nxt;
            busy                       <= (state_nxt == ST_RUN);
            halted                     <= (state_nxt == ST_HALT);
            illegal                    <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: vector table, directed corner sequences, random programs vs. a cycle model.
module tb_instr_fetch_decode;

    localparam int HW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [23:0] prog_data = '0;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic [7:0]  pc;
    logic        busy, halted, illegal;

    instr_fetch_decode #(.HAZARD_WINDOW(HW), .PROG_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .issue_valid(issue_valid), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int a);
        logic [23:0] w;
        w = {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
        return w;
    endfunction

    // ---------------- reference model ----------------
    // Hazards are tracked as "RUN-cycle number at which each register was last issued as rd".
    logic [23:0] ref_mem [256];
    int m_st;                         // 0 idle, 1 run, 2 halt
    int m_pc, m_ill, m_vld, m_func, m_rs1, m_rs2, m_rd, m_addr;
    int last_wr [16];
    int run_cyc;

    task automatic model_step();
        logic [23:0] w;
        int f;
        if (prog_we && m_st != 1) ref_mem[prog_addr] = prog_data;
        if (rst) begin
            m_st = 0; m_pc = 0; m_ill = 0; m_vld = 0; m_func = 15;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_addr = 0;
        end else begin
            m_vld = 0; m_func = 15;
            if (m_st != 1) begin
                if (start) begin
                    m_st = 1; m_pc = 0; m_ill = 0; run_cyc = 0;
                    for (int r = 0; r < 16; r++) last_wr[r] = -1000;
                end
            end else begin
                w = ref_mem[m_pc];
                f = int'(w[23:20]);
                if (f <= 4) begin
                    if (run_cyc - last_wr[w[15:12]] > HW && run_cyc - last_wr[w[11:8]] > HW) begin
                        m_vld = 1; m_func = f;
                        m_rd = int'(w[19:16]); m_rs1 = int'(w[15:12]);
                        m_rs2 = int'(w[11:8]); m_addr = int'(w[7:0]);
                        last_wr[w[19:16]] = run_cyc;
                        m_pc = (m_pc + 1) % 256;
                    end
                end else if (f == 14) begin
                    m_pc = int'(w[7:0]);
                end else if (f == 15) begin
                    m_st = 2;
                end else begin
                    m_ill = 1;
                    m_pc = (m_pc + 1) % 256;
                end
                run_cyc++;
            end
        end
    endtask

    task automatic compare_model();
        chk("model issue_valid", issue_valid, m_vld);
        chk("model func", func, m_func);
        chk("model pc", pc, m_pc);
        chk("model busy", busy, m_st == 1);
        chk("model halted", halted, m_st == 2);
        chk("model illegal", illegal, m_ill);
        if (m_vld != 0) begin
            chk("model rd", rd, m_rd);
            chk("model rs1", rs1, m_rs1);
            chk("model rs2", rs2, m_rs2);
            chk("model addr", addr, m_addr);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic put(input int a, input logic [23:0] w);
        prog_we = 1'b1; prog_addr = a[7:0]; prog_data = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    function automatic logic [23:0] rand_instr(input int len);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 80) return mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 255)));
        if (r < 88) return mk(14, 0, 0, 0, int'($urandom_range(0, len - 1)));
        if (r < 94) return mk(int'($urandom_range(5, 13)), 1, 2, 3, 0);
        return mk(15, 0, 0, 0, 0);
    endfunction

    typedef struct {
        logic [23:0] instr;
        logic        exp_vld;
        logic [3:0]  exp_func;
        logic [7:0]  exp_pc;
        logic        exp_ill;
        logic        exp_halt;
    } vec_t;

    initial begin
        vec_t vt [10];
        int   prev_pc;
        bit   seen_255, wrapped;

        vt[0] = '{mk(0, 3, 1, 2, 8'h12), 1'b1, 4'h0, 8'd1, 1'b0, 1'b0};
        vt[1] = '{mk(1, 4, 5, 6, 8'h00), 1'b1, 4'h1, 8'd1, 1'b0, 1'b0};
        vt[2] = '{mk(2, 7, 3, 1, 8'h40), 1'b1, 4'h2, 8'd1, 1'b0, 1'b0};
        vt[3] = '{mk(3, 9, 8, 8, 8'hFF), 1'b1, 4'h3, 8'd1, 1'b0, 1'b0};
        vt[4] = '{mk(4, 2, 2, 2, 8'h01), 1'b1, 4'h4, 8'd1, 1'b0, 1'b0};
        vt[5] = '{mk(5, 1, 2, 3, 8'h00), 1'b0, 4'hF, 8'd1, 1'b1, 1'b0};
        vt[6] = '{mk(13, 1, 2, 3, 8'h00), 1'b0, 4'hF, 8'd1, 1'b1, 1'b0};
        vt[7] = '{mk(14, 0, 0, 0, 8'h09), 1'b0, 4'hF, 8'd9, 1'b0, 1'b0};
        vt[8] = '{mk(15, 0, 0, 0, 8'h00), 1'b0, 4'hF, 8'd0, 1'b0, 1'b1};
        vt[9] = '{mk(14, 0, 0, 0, 8'hFF), 1'b0, 4'hF, 8'd255, 1'b0, 1'b0};

        // reset state
        reset_dut();
        chk("reset rs1", rs1, 0);
        chk("reset rs2", rs2, 0);
        chk("reset rd", rd, 0);
        chk("reset addr", addr, 0);
        chk("reset func", func, 4'hF);
        chk("reset busy", busy, 0);
        for (int a = 0; a < 256; a++) put(a, mk(15, 0, 0, 0, 0));

        // single-instruction table; write and start land in the same cycle
        for (int i = 0; i < 10; i++) begin
            reset_dut();
            prog_we = 1'b1; prog_addr = 8'd0; prog_data = vt[i].instr; start = 1'b1;
            tick();
            prog_we = 1'b0; start = 1'b0;
            tick();
            chk($sformatf("vec%0d issue_valid", i), issue_valid, vt[i].exp_vld);
            chk($sformatf("vec%0d func", i), func, vt[i].exp_func);
            chk($sformatf("vec%0d pc", i), pc, vt[i].exp_pc);
            chk($sformatf("vec%0d illegal", i), illegal, vt[i].exp_ill);
            chk($sformatf("vec%0d halted", i), halted, vt[i].exp_halt);
        end

        // ADD, SUB, HALT: back-to-back issue
        reset_dut();
        put(0, mk(0, 3, 1, 2, 0)); put(1, mk(1, 4, 5, 6, 0)); put(2, mk(15, 0, 0, 0, 0));
        go();
        tick(); chk("seq1 add vld", issue_valid, 1); chk("seq1 add func", func, 0);
        tick(); chk("seq1 sub vld", issue_valid, 1); chk("seq1 sub func", func, 1);
        tick(); chk("seq1 halted", halted, 1); chk("seq1 pc", pc, 2); chk("seq1 vld", issue_valid, 0);

        // RAW dependency: three bubbles
        reset_dut();
        put(0, mk(0, 3, 1, 2, 0)); put(1, mk(2, 7, 3, 1, 0)); put(2, mk(15, 0, 0, 0, 0));
        go();
        tick(); chk("seq2 add vld", issue_valid, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("seq2 bubble%0d vld", k), issue_valid, 0);
            chk($sformatf("seq2 bubble%0d func", k), func, 4'hF);
            chk($sformatf("seq2 bubble%0d pc", k), pc, 1);
        end
        tick(); chk("seq2 mul vld", issue_valid, 1); chk("seq2 mul func", func, 2); chk("seq2 mul rd", rd, 7);
        tick(); chk("seq2 halted", halted, 1);

        // jump
        reset_dut();
        put(0, mk(14, 0, 0, 0, 5)); put(5, mk(0, 1, 2, 2, 0)); put(6, mk(15, 0, 0, 0, 0));
        go();
        tick(); chk("seq3 jmp vld", issue_valid, 0); chk("seq3 jmp pc", pc, 5);
        tick(); chk("seq3 add vld", issue_valid, 1); chk("seq3 add func", func, 0); chk("seq3 add rd", rd, 1);
        tick(); chk("seq3 halted", halted, 1); chk("seq3 halt pc", pc, 6);

        // illegal opcode, cleared by the next start
        reset_dut();
        put(0, mk(7, 1, 2, 3, 0)); put(1, mk(15, 0, 0, 0, 0));
        go();
        tick(); chk("seq4 illegal", illegal, 1); chk("seq4 vld", issue_valid, 0);
        tick(); chk("seq4 halted", halted, 1); chk("seq4 illegal held", illegal, 1);
        go(); chk("seq4 illegal cleared", illegal, 0);
        reset_dut();

        // reset mid-run
        for (int a = 0; a < 4; a++) put(a, mk(0, 1, 2, 3, a));
        put(4, mk(15, 0, 0, 0, 0));
        go();
        tick(); tick(); chk("seq5 2nd issue", issue_valid, 1);
        reset_dut();
        chk("seq5 busy", busy, 0); chk("seq5 vld", issue_valid, 0);
        chk("seq5 func", func, 4'hF); chk("seq5 pc", pc, 0);

        // write during RUN to the next fetch address is ignored
        go();
        tick();
        prog_we = 1'b1; prog_addr = 8'd1; prog_data = mk(1, 5, 6, 7, 0);
        tick();
        prog_we = 1'b0;
        chk("seq6 old word vld", issue_valid, 1); chk("seq6 old word func", func, 0);
        reset_dut();

        // pc wraps 255 -> 0
        put(0, mk(14, 0, 0, 0, 250));
        for (int a = 250; a < 256; a++) put(a, mk(0, 0, 1, 2, 0));
        go();
        seen_255 = 1'b0; wrapped = 1'b0; prev_pc = int'(pc);
        for (int k = 0; k < 40 && !wrapped; k++) begin
            tick();
            if (pc == 8'd255) seen_255 = 1'b1;
            if (prev_pc == 255 && pc == 8'd0) wrapped = 1'b1;
            prev_pc = int'(pc);
        end
        chk("wrap saw pc 255", seen_255, 1);
        chk("wrap 255 to 0", wrapped, 1);
        reset_dut();

        // random programs
        for (int it = 0; it < 25; it++) begin
            int len;
            reset_dut();
            len = int'($urandom_range(4, 16));
            for (int i = 0; i < len - 1; i++) put(i, rand_instr(len));
            put(len - 1, mk(15, 0, 0, 0, 0));
            go();
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    prog_we = 1'b1;
                    prog_addr = 8'($urandom_range(0, len));
                    prog_data = rand_instr(len);
                end
                start = ($urandom_range(0, 19) == 0);
                tick();
                prog_we = 1'b0; start = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
